calc_tx_queue: RTL and testbench
================================

CALC_TX_QUEUE -- requirements
Module: calc_tx_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each queued result word.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO depth in words; power of two, >=2.
REQ-003 SHALL have parameter DIV_W, default 8: width of the divider value.
REQ-004 SHALL have port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port DataIn, input, DATA_W: word to enqueue.
REQ-007 SHALL have port Push, input, 1: enqueue request, sampled every Clk edge.
REQ-008 SHALL have port ConfigDiv, input, 1: load request for the divider value.
REQ-009 SHALL have port Din, input, DIV_W: divider value.
REQ-010 SHALL have outputs Full (1), Empty (1) and Count ($clog2(DEPTH)+1): registered FIFO status.
REQ-011 SHALL have outputs ClkTx (1), DOutValid (1) and DataOut (1): serial transmit clock, frame-valid flag and data bit.
REQ-012 SHALL have outputs TxDone (1), Busy (1) and Overflow (1): frame-end pulse, transmitter active, sticky drop flag.

Function
REQ-013 Push with Full=0 SHALL write DataIn at the tail; Count, Empty and Full update after the same edge.
REQ-014 Push with Full=1 SHALL drop the word and set Overflow, even if a pop occurs on the same edge.
REQ-015 A simultaneous accepted push and pop SHALL leave Count unchanged.
REQ-016 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE SHALL go to LOAD when Empty=0.
REQ-018 LOAD SHALL pop the head word into the shift register, then go to SHIFT.
REQ-019 SHIFT SHALL transmit all frame bits, then go to DONE.
REQ-020 DONE SHALL assert TxDone for exactly 1 cycle, then go to IDLE.
REQ-021 Busy SHALL be 1 in LOAD, SHIFT and DONE; DOutValid SHALL be 1 only in SHIFT.
REQ-022 A frame SHALL be DATA_W bits, MSB first; DataOut SHALL hold the current bit and be 0 outside SHIFT.
REQ-023 Each bit SHALL last 2*Div Clk cycles: ClkTx=0 for the first Div cycles and 1 for the last Div cycles; ClkTx SHALL be 0 outside SHIFT.
REQ-024 Latency: a push accepted at edge k into an empty, idle block SHALL give state LOAD after edge k+1 and DOutValid=1 after edge k+2.
REQ-025 Back-to-back frames SHALL be separated by exactly 3 cycles with DOutValid=0 (DONE, IDLE, LOAD).
REQ-026 ConfigDiv=1 with Busy=0 SHALL load Div<=Din, with Din=0 loaded as 1.
REQ-027 ConfigDiv=1 with Busy=1 SHALL be ignored.
REQ-028 Overflow SHALL stay set until Reset.

Reset
REQ-029 Reset=1 at an edge SHALL clear the FIFO, giving Count=0, Empty=1 and Full=0.
REQ-030 Reset=1 at an edge SHALL set the FSM to IDLE and Div=1.
REQ-031 Reset=1 at an edge SHALL drive ClkTx, DOutValid, DataOut, TxDone, Busy and Overflow to 0.
REQ-032 Reset SHALL take priority over Push and ConfigDiv.
REQ-033 Reset mid-frame SHALL abort the frame with no TxDone pulse.

Configuration
REQ-034 With macro CALC_TX_PARITY_EN defined, the frame SHALL be DATA_W+1 bits, the last bit after the LSB being even parity (XOR of the data bits).
REQ-035 With CALC_TX_PARITY_EN undefined, the frame SHALL be DATA_W bits and no parity logic SHALL exist.

Verification (DATA_W=8, DEPTH=4)
REQ-036 Div=1, push 0xA5 -> DataOut 1,0,1,0,0,1,0,1, each bit 2 cycles with ClkTx 0 then 1; then TxDone 1-cycle pulse; with parity, a 9th bit of 0.
REQ-037 Div=3, six pushes on consecutive edges into an empty queue -> Full after the 5th push, 6th word dropped, Overflow=1, words 1-5 sent in order.
REQ-038 ConfigDiv with Din=0 while idle -> bit period 2 cycles; ConfigDiv with Din=5 while Busy -> period unchanged.
REQ-039 Reset pulsed mid-bit 3 -> next cycle all outputs 0 and Count=0; a following push of 0x3C -> complete correct frame.
REQ-040 Div=2, two words queued -> two frames of 8x4 cycles each, with 3 cycles of DOutValid=0 between them.

Source files
------------

// File: rtl/calc_tx_queue.sv
// Result-word FIFO feeding an MSB-first serial transmitter with a programmable bit clock.
// Optional even-parity bit after the LSB when CALC_TX_PARITY_EN is defined.
module calc_tx_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [DATA_W-1:0]        DataIn,
  input  logic                     Push,
  input  logic                     ConfigDiv,
  input  logic [DIV_W-1:0]         Din,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     ClkTx,
  output logic                     DOutValid,
  output logic                     DataOut,
  output logic                     TxDone,
  output logic                     Busy,
  output logic                     Overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = DIV_W + 1;
`ifdef CALC_TX_PARITY_EN
  localparam int unsigned FRAME_W = DATA_W + 1;
`else
  localparam int unsigned FRAME_W = DATA_W;
`endif
  localparam int unsigned BW = $clog2(FRAME_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_nxt;
  logic               push_ok;
  logic               pop;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] shreg_nxt;
  logic [FRAME_W-1:0] load_word;
  logic [PW-1:0]      cyc;
  logic [PW-1:0]      cyc_nxt;
  logic [PW-1:0]      period_last;
  logic [BW-1:0]      bit_idx;
  logic [BW-1:0]      bit_nxt;
  logic [DIV_W-1:0]   div;

  logic               valid_nxt;
  logic               data_nxt;
  logic               clk_tx_nxt;
  logic               done_nxt;
  logic               busy_nxt;

  // Words pushed while full are dropped, regardless of a same-edge pop.
  assign push_ok   = Push & ~Full;
  assign count_nxt = Count + CW'(push_ok) - CW'(pop);

`ifdef CALC_TX_PARITY_EN
  assign load_word = {mem[rd_ptr], ^mem[rd_ptr]};
`else
  assign load_word = mem[rd_ptr];
`endif

  assign period_last = {div, 1'b0} - PW'(1);

  always_ff @(posedge Clk) begin
    if (!Reset && push_ok) begin
      mem[wr_ptr] <= DataIn;
    end
  end

  // FIFO pointers and registered status.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Empty    <= 1'b1;
      Full     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      Count <= count_nxt;
      Empty <= (count_nxt == '0);
      Full  <= (count_nxt == CW'(DEPTH));
      if (Push && Full) Overflow <= 1'b1;
    end
  end

  // Next-state and next-output logic; outputs are registered from the next-state view.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cyc_nxt   = cyc;
    bit_nxt   = bit_idx;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!Empty) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        pop       = 1'b1;
        shreg_nxt = load_word;
        cyc_nxt   = '0;
        bit_nxt   = '0;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (cyc == period_last) begin
          if (bit_idx == BW'(FRAME_W - 1)) begin
            state_nxt = S_DONE;
          end else begin
            cyc_nxt   = '0;
            bit_nxt   = bit_idx + BW'(1);
            shreg_nxt = {shreg[FRAME_W-2:0], 1'b0};
          end
        end else begin
          cyc_nxt = cyc + PW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    valid_nxt  = (state_nxt == S_SHIFT);
    data_nxt   = valid_nxt & shreg_nxt[FRAME_W-1];
    clk_tx_nxt = valid_nxt & (cyc_nxt >= {1'b0, div});
    done_nxt   = (state_nxt == S_DONE);
    busy_nxt   = (state_nxt != S_IDLE);
  end

  // FSM state, transmit datapath and divider register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cyc       <= '0;
      bit_idx   <= '0;
      div       <= DIV_W'(1);
      ClkTx     <= 1'b0;
      DOutValid <= 1'b0;
      DataOut   <= 1'b0;
      TxDone    <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cyc       <= cyc_nxt;
      bit_idx   <= bit_nxt;
      ClkTx     <= clk_tx_nxt;
      DOutValid <= valid_nxt;
      DataOut   <= data_nxt;
      TxDone    <= done_nxt;
      Busy      <= busy_nxt;
      // A zero divider would stall the bit counter, so it is promoted to 1.
      if (ConfigDiv && !Busy) begin
        div <= (Din == '0) ? DIV_W'(1) : Din;
      end
    end
  end

endmodule

// File: tb/tb_calc_tx_queue.sv
// Directed bench for calc_tx_queue (DATA_W=8, DEPTH=4); follows CALC_TX_PARITY_EN if defined.
module tb_calc_tx_queue;

  logic       Clk;
  logic       Reset;
  logic [7:0] DataIn;
  logic       Push;
  logic       ConfigDiv;
  logic [7:0] Din;
  logic       Full;
  logic       Empty;
  logic [2:0] Count;
  logic       ClkTx;
  logic       DOutValid;
  logic       DataOut;
  logic       TxDone;
  logic       Busy;
  logic       Overflow;

  int compared   = 0;
  int mismatched = 0;

  calc_tx_queue #(.DATA_W(8), .DEPTH(4), .DIV_W(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .Push      (Push),
    .ConfigDiv (ConfigDiv),
    .Din       (Din),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .ClkTx     (ClkTx),
    .DOutValid (DOutValid),
    .DataOut   (DataOut),
    .TxDone    (TxDone),
    .Busy      (Busy),
    .Overflow  (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".clktx"}, 32'(ClkTx), 32'd0);
    chk({tag, ".valid"}, 32'(DOutValid), 32'd0);
    chk({tag, ".data"},  32'(DataOut), 32'd0);
    chk({tag, ".done"},  32'(TxDone), 32'd0);
  endtask

  // Checks one frame cycle by cycle, starting 'skip' cycles into it; ends one cycle after DONE.
  task automatic frame(input string tag, input logic [7:0] word, input int dv, input int skip);
    logic [8:0] fw;
    int nbits;
`ifdef CALC_TX_PARITY_EN
    fw    = {word, ^word};
    nbits = 9;
`else
    fw    = {1'b0, word};
    nbits = 8;
`endif
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 2 * dv; c++) begin
        if (b * 2 * dv + c >= skip) begin
          chk({tag, ".valid"}, 32'(DOutValid), 32'd1);
          chk({tag, ".bit"},   32'(DataOut), 32'(fw[nbits-1-b]));
          chk({tag, ".clktx"}, 32'(ClkTx), (c >= dv) ? 32'd1 : 32'd0);
          chk({tag, ".done0"}, 32'(TxDone), 32'd0);
          tick();
        end
      end
    end
    chk({tag, ".done"},      32'(TxDone), 32'd1);
    chk({tag, ".done_busy"}, 32'(Busy), 32'd1);
    chk({tag, ".done_vld"},  32'(DOutValid), 32'd0);
    chk({tag, ".done_data"}, 32'(DataOut), 32'd0);
    tick();
    chk({tag, ".post_done"}, 32'(TxDone), 32'd0);
  endtask

  // IDLE and LOAD cycles between back-to-back frames.
  task automatic gap(input string tag);
    chk({tag, ".idle_vld"}, 32'(DOutValid), 32'd0);
    tick();
    chk({tag, ".load_vld"}, 32'(DOutValid), 32'd0);
    chk({tag, ".load_busy"}, 32'(Busy), 32'd1);
    tick();
  endtask

  initial begin
    Reset = 1'b1; Push = 1'b0; DataIn = '0; ConfigDiv = 1'b0; Din = '0;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst.count", 32'(Count), 32'd0);
    chk("rst.empty", 32'(Empty), 32'd1);
    chk("rst.full",  32'(Full), 32'd0);
    chk("rst.busy",  32'(Busy), 32'd0);
    chk("rst.ovf",   32'(Overflow), 32'd0);
    chk_idle_outputs("rst");

    // Div=1, single word 0xA5, latency check.
    DataIn = 8'hA5; Push = 1'b1;
    tick();
    Push = 1'b0;
    chk("a5.count1", 32'(Count), 32'd1);
    chk("a5.empty0", 32'(Empty), 32'd0);
    chk("a5.busy_idle", 32'(Busy), 32'd0);
    tick();
    chk("a5.load_busy", 32'(Busy), 32'd1);
    chk("a5.load_vld",  32'(DOutValid), 32'd0);
    tick();
    chk("a5.popped", 32'(Empty), 32'd1);
    frame("a5", 8'hA5, 1, 0);
    chk("a5.idle_busy", 32'(Busy), 32'd0);
    chk_idle_outputs("a5.idle");

    // Div=3, six pushes on consecutive edges; sixth word dropped.
    ConfigDiv = 1'b1; Din = 8'd3;
    tick();
    ConfigDiv = 1'b0;
    Push = 1'b1;
    DataIn = 8'h11; tick(); chk("q.count1", 32'(Count), 32'd1);
    DataIn = 8'h22; tick(); chk("q.count2", 32'(Count), 32'd2);
    DataIn = 8'h33; tick(); chk("q.count3", 32'(Count), 32'd2);
    DataIn = 8'h44; tick(); chk("q.count4", 32'(Count), 32'd3);
    chk("q.full4", 32'(Full), 32'd0);
    DataIn = 8'h55; tick(); chk("q.count5", 32'(Count), 32'd4);
    chk("q.full5", 32'(Full), 32'd1);
    chk("q.ovf5",  32'(Overflow), 32'd0);
    DataIn = 8'h66; tick(); chk("q.count6", 32'(Count), 32'd4);
    chk("q.ovf6",  32'(Overflow), 32'd1);
    Push = 1'b0;
    frame("q1", 8'h11, 3, 3);
    gap("q12");
    frame("q2", 8'h22, 3, 0);
    gap("q23");
    frame("q3", 8'h33, 3, 0);
    gap("q34");
    frame("q4", 8'h44, 3, 0);
    gap("q45");
    frame("q5", 8'h55, 3, 0);
    chk("q.end_busy",  32'(Busy), 32'd0);
    chk("q.end_empty", 32'(Empty), 32'd1);
    tick();
    chk("q.no_sixth",  32'(Busy), 32'd0);
    chk("q.ovf_sticky", 32'(Overflow), 32'd1);

    // Din=0 loads 1 while idle; Din=5 while busy is ignored.
    ConfigDiv = 1'b1; Din = 8'd0;
    tick();
    ConfigDiv = 1'b0;
    DataIn = 8'h96; Push = 1'b1;
    tick();
    Push = 1'b0;
    tick();
    chk("cfg.busy", 32'(Busy), 32'd1);
    ConfigDiv = 1'b1; Din = 8'd5;
    tick();
    ConfigDiv = 1'b0;
    frame("cfg", 8'h96, 1, 0);
    chk("cfg.ovf_sticky", 32'(Overflow), 32'd1);

    // Reset in the middle of bit 3, with Push/ConfigDiv asserted at the reset edge.
    DataIn = 8'h5A; Push = 1'b1;
    tick();
    Push = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("mid.valid", 32'(DOutValid), 32'd1);
    Reset = 1'b1; Push = 1'b1; DataIn = 8'hFF; ConfigDiv = 1'b1; Din = 8'd7;
    tick();
    Reset = 1'b0; Push = 1'b0; ConfigDiv = 1'b0;
    chk("mid.count", 32'(Count), 32'd0);
    chk("mid.empty", 32'(Empty), 32'd1);
    chk("mid.full",  32'(Full), 32'd0);
    chk("mid.busy",  32'(Busy), 32'd0);
    chk("mid.ovf",   32'(Overflow), 32'd0);
    chk_idle_outputs("mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid.no_done", 32'(TxDone), 32'd0);
      chk("mid.stay_idle", 32'(Busy), 32'd0);
    end
    DataIn = 8'h3C; Push = 1'b1;
    tick();
    Push = 1'b0;
    tick();
    tick();
    frame("r3c", 8'h3C, 1, 0);

    // Div=2, two frames; second push coincides with the LOAD pop.
    ConfigDiv = 1'b1; Din = 8'd2;
    tick();
    ConfigDiv = 1'b0;
    DataIn = 8'h81; Push = 1'b1;
    tick();
    Push = 1'b0;
    tick();
    chk("d2.load_busy", 32'(Busy), 32'd1);
    DataIn = 8'h7E; Push = 1'b1;
    tick();
    Push = 1'b0;
    chk("d2.pushpop_count", 32'(Count), 32'd1);
    frame("d2a", 8'h81, 2, 0);
    gap("d2gap");
    frame("d2b", 8'h7E, 2, 0);
    chk("d2.end_busy",  32'(Busy), 32'd0);
    chk("d2.end_count", 32'(Count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
